// File: rtl/day_night_sequencer.sv
// Day/night fade sequencer: watches the game score, schedules nights and
// steps a 4-bit fade level at a fixed prescaled cadence.
module day_night_sequencer #(
    parameter int unsigned PERIOD      = 700,
    parameter int unsigned DARK_SPAN   = 150,
    parameter int unsigned STEP_CYCLES = 8388608
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        running,
    input  logic [13:0] game_score,
    output logic [3:0]  fade_level,
    output logic        is_night,
    output logic        fading
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [14:0]      PERIOD_W = 15'(PERIOD);
    localparam logic [15:0]      SPAN_W   = 16'(DARK_SPAN);

    typedef enum logic [1:0] {
        LIGHT    = 2'd0,
        TO_DARK  = 2'd1,
        DARK     = 2'd2,
        TO_LIGHT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [14:0]      next_dark;
    logic [14:0]      dark_start;
    logic [13:0]      last_score;

    logic             tick_c;
    logic [14:0]      score_c;
    logic [15:0]      dark_end_c;
    logic             onset_c;
    logic             end_c;

    assign tick_c     = (cnt == CNT_MAX);
    assign score_c    = {1'b0, game_score};
    // One bit wider so the night-end threshold cannot wrap.
    assign dark_end_c = {1'b0, dark_start} + SPAN_W;
    assign onset_c    = (state == LIGHT || state == TO_LIGHT) && (score_c >= next_dark);
    assign end_c      = (state == TO_DARK || state == DARK) && ({1'b0, score_c} >= dark_end_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LIGHT;
            fade_level <= 4'd0;
            is_night   <= 1'b0;
            fading     <= 1'b0;
            cnt        <= '0;
            next_dark  <= PERIOD_W;
            dark_start <= 15'd0;
            last_score <= 14'd0;
        end else if (running) begin
            last_score <= game_score;
            cnt        <= tick_c ? '0 : cnt + CNT_W'(1);

            if (game_score < last_score) begin
                // Score went backwards: a new game started.
                state      <= LIGHT;
                fade_level <= 4'd0;
                is_night   <= 1'b0;
                fading     <= 1'b0;
                next_dark  <= PERIOD_W;
                dark_start <= 15'd0;
            end else if (onset_c) begin
                state      <= TO_DARK;
                is_night   <= 1'b1;
                fading     <= 1'b1;
                dark_start <= next_dark;
                next_dark  <= next_dark + PERIOD_W;
            end else if (end_c) begin
                state    <= TO_LIGHT;
                is_night <= 1'b0;
                fading   <= 1'b1;
            end else if (tick_c) begin
                // Steps clamp at the rails so a reversed ramp can never wrap.
                case (state)
                    TO_DARK: begin
                        if (fade_level >= 4'd14) begin
                            fade_level <= 4'd15;
                            state      <= DARK;
                            fading     <= 1'b0;
                        end else begin
                            fade_level <= fade_level + 4'd1;
                        end
                    end
                    TO_LIGHT: begin
                        if (fade_level <= 4'd1) begin
                            fade_level <= 4'd0;
                            state      <= LIGHT;
                            fading     <= 1'b0;
                        end else begin
                            fade_level <= fade_level - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
